// File: rtl/mips_multicycle_ctrl_pkg.sv
// Shared constants for the multicycle MIPS control unit: opcodes, functs, ALU codes, FSM states.
// Also holds the packed control-word type that the FSM decodes into.
package mips_multicycle_ctrl_pkg;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;

  localparam logic [5:0] FN_ADD = 6'h20;
  localparam logic [5:0] FN_SUB = 6'h22;
  localparam logic [5:0] FN_AND = 6'h24;
  localparam logic [5:0] FN_OR  = 6'h25;
  localparam logic [5:0] FN_SLT = 6'h2A;

  localparam logic [3:0] ALU_AND = 4'h0;
  localparam logic [3:0] ALU_OR  = 4'h1;
  localparam logic [3:0] ALU_ADD = 4'h2;
  localparam logic [3:0] ALU_SUB = 4'h6;
  localparam logic [3:0] ALU_SLT = 4'h7;

  localparam logic [3:0] S_FETCH  = 4'd0;
  localparam logic [3:0] S_DECODE = 4'd1;
  localparam logic [3:0] S_MEMADR = 4'd2;
  localparam logic [3:0] S_MEMRD  = 4'd3;
  localparam logic [3:0] S_MEMWB  = 4'd4;
  localparam logic [3:0] S_MEMWR  = 4'd5;
  localparam logic [3:0] S_EXEC   = 4'd6;
  localparam logic [3:0] S_ALUWB  = 4'd7;
  localparam logic [3:0] S_ADDIEX = 4'd8;
  localparam logic [3:0] S_ADDIWB = 4'd9;
  localparam logic [3:0] S_BRANCH = 4'd10;
  localparam logic [3:0] S_JUMP   = 4'd11;
  localparam logic [3:0] S_TRAP   = 4'd12;

  typedef struct packed {
    logic       pc_write;
    logic       pc_write_cond;
    logic       ir_write;
    logic       iord;
    logic       mem_read;
    logic       mem_write;
    logic       reg_write;
    logic       reg_dst;
    logic       mem_to_reg;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] pc_src;
    logic [3:0] alu_op;
    logic       illegal;
  } ctrl_t;

endpackage

// File: rtl/mips_multicycle_ctrl_alu_decoder.sv
// R-type funct to ALU opcode map with a validity flag for the EXEC state.
// Latency: combinational. Backpressure: none, pure decode.
// Flow: no handshake; output follows funct every cycle.
module mips_multicycle_ctrl_alu_decoder
  import mips_multicycle_ctrl_pkg::*;
(
  input  logic [5:0] funct,
  output logic [3:0] alu_op,
  output logic       funct_valid
);

  always_comb begin
    alu_op      = ALU_ADD;
    funct_valid = 1'b1;
    case (funct)
      FN_ADD:  alu_op = ALU_ADD;
      FN_SUB:  alu_op = ALU_SUB;
      FN_AND:  alu_op = ALU_AND;
      FN_OR:   alu_op = ALU_OR;
      FN_SLT:  alu_op = ALU_SLT;
      default: funct_valid = 1'b0;
    endcase
  end

endmodule

// File: rtl/mips_multicycle_ctrl.sv
// Multicycle MIPS control FSM: sequences fetch/decode/execute/memory/writeback.
// Latency: 3-5 cycles per instruction plus memory wait cycles.
// Backpressure: FETCH, MEMRD and MEMWR hold their request until mem_ready_i.
module mips_multicycle_ctrl
  import mips_multicycle_ctrl_pkg::*;
#(
  parameter int ALU_OP_W     = 4,
  parameter bit MEM_WAIT_EN  = 1'b1,
  parameter bit ILLEGAL_TRAP = 1'b1
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [5:0]          op_i,
  input  logic [5:0]          funct_i,
  input  logic                zero_i,
  input  logic                mem_ready_i,
  output logic                pc_write,
  output logic                pc_write_cond,
  output logic                ir_write,
  output logic                iord,
  output logic                mem_read,
  output logic                mem_write,
  output logic                reg_write,
  output logic                reg_dst,
  output logic                mem_to_reg,
  output logic                alu_src_a,
  output logic [1:0]          alu_src_b,
  output logic [1:0]          pc_src,
  output logic [ALU_OP_W-1:0] alu_op,
  output logic                illegal_o,
  output logic [3:0]          state_o
);

  logic [3:0] state;
  logic [3:0] state_nxt;
  logic [3:0] exec_alu_op;
  logic [3:0] alu_op_q;
  logic       funct_valid;
  logic       ready;
  ctrl_t      ctrl;
  ctrl_t      ctrl_o;

  assign ready = MEM_WAIT_EN ? mem_ready_i : 1'b1;

  mips_multicycle_ctrl_alu_decoder u_alu_decoder (
    .funct       (funct_i),
    .alu_op      (exec_alu_op),
    .funct_valid (funct_valid)
  );

  always_comb begin
    state_nxt = S_FETCH;
    case (state)
      S_FETCH:  state_nxt = ready ? S_DECODE : S_FETCH;
      S_DECODE: begin
        case (op_i)
          OP_LW, OP_SW: state_nxt = S_MEMADR;
          OP_RTYPE:     state_nxt = S_EXEC;
          OP_ADDI:      state_nxt = S_ADDIEX;
          OP_BEQ:       state_nxt = S_BRANCH;
          OP_J:         state_nxt = S_JUMP;
          default:      state_nxt = ILLEGAL_TRAP ? S_TRAP : S_FETCH;
        endcase
      end
      S_MEMADR: state_nxt = (op_i == OP_LW) ? S_MEMRD : S_MEMWR;
      S_MEMRD:  state_nxt = ready ? S_MEMWB : S_MEMRD;
      S_MEMWR:  state_nxt = ready ? S_FETCH : S_MEMWR;
      S_EXEC: begin
        if (funct_valid)
          state_nxt = S_ALUWB;
        else
          state_nxt = ILLEGAL_TRAP ? S_TRAP : S_FETCH;
      end
      S_ADDIEX: state_nxt = S_ADDIWB;
      // Writeback, branch, jump, trap and the unused encodings all return to FETCH.
      default:  state_nxt = S_FETCH;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= S_FETCH;
      alu_op_q <= ALU_ADD;
    end else begin
      state <= state_nxt;
      if (state == S_EXEC)
        alu_op_q <= exec_alu_op;
    end
  end

  always_comb begin
    ctrl = '0;
    case (state)
      S_FETCH: begin
        ctrl.mem_read  = 1'b1;
        ctrl.alu_src_b = 2'd1;
        ctrl.alu_op    = ALU_ADD;
        ctrl.ir_write  = ready;
        ctrl.pc_write  = ready;
      end
      S_DECODE: begin
        ctrl.alu_src_b = 2'd3;
        ctrl.alu_op    = ALU_ADD;
      end
      S_MEMADR, S_ADDIEX: begin
        ctrl.alu_src_a = 1'b1;
        ctrl.alu_src_b = 2'd2;
        ctrl.alu_op    = ALU_ADD;
      end
      S_MEMRD: begin
        ctrl.mem_read = 1'b1;
        ctrl.iord     = 1'b1;
      end
      S_MEMWB: begin
        ctrl.reg_write  = 1'b1;
        ctrl.mem_to_reg = 1'b1;
      end
      S_MEMWR: begin
        ctrl.mem_write = 1'b1;
        ctrl.iord      = 1'b1;
      end
      S_EXEC: begin
        ctrl.alu_src_a = 1'b1;
        ctrl.alu_op    = exec_alu_op;
      end
      S_ALUWB: begin
        ctrl.reg_write = 1'b1;
        ctrl.reg_dst   = 1'b1;
        ctrl.alu_op    = alu_op_q;
      end
      S_ADDIWB: ctrl.reg_write = 1'b1;
      S_BRANCH: begin
        ctrl.alu_src_a     = 1'b1;
        ctrl.alu_op        = ALU_SUB;
        ctrl.pc_src        = 2'd1;
        ctrl.pc_write_cond = zero_i;
      end
      S_JUMP: begin
        ctrl.pc_write = 1'b1;
        ctrl.pc_src   = 2'd2;
      end
      S_TRAP:  ctrl.illegal = 1'b1;
      default: ctrl = '0;
    endcase
  end

  // Reset forces every output low, even before the state register settles.
  assign ctrl_o = rst ? '0 : ctrl;

  assign pc_write      = ctrl_o.pc_write;
  assign pc_write_cond = ctrl_o.pc_write_cond;
  assign ir_write      = ctrl_o.ir_write;
  assign iord          = ctrl_o.iord;
  assign mem_read      = ctrl_o.mem_read;
  assign mem_write     = ctrl_o.mem_write;
  assign reg_write     = ctrl_o.reg_write;
  assign reg_dst       = ctrl_o.reg_dst;
  assign mem_to_reg    = ctrl_o.mem_to_reg;
  assign alu_src_a     = ctrl_o.alu_src_a;
  assign alu_src_b     = ctrl_o.alu_src_b;
  assign pc_src        = ctrl_o.pc_src;
  assign alu_op        = ALU_OP_W'(ctrl_o.alu_op);
  assign illegal_o     = ctrl_o.illegal;
  assign state_o       = rst ? 4'd0 : state;

endmodule

// File: tb/tb_mips_multicycle_ctrl.sv
// Bench for mips_multicycle_ctrl: instruction-level model plus literal checks.
module tb_mips_multicycle_ctrl;

  typedef struct packed {
    logic [3:0] state;
    logic       pc_write;
    logic       pc_write_cond;
    logic       ir_write;
    logic       iord;
    logic       mem_read;
    logic       mem_write;
    logic       reg_write;
    logic       reg_dst;
    logic       mem_to_reg;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] pc_src;
    logic [3:0] alu_op;
    logic       illegal;
  } obs_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst1, rst2, mem_ready, zero;
  logic       mem_ready2;
  logic [5:0] op, funct;
  assign mem_ready2 = 1'b0;

  logic pcw1, pcwc1, irw1, iord1, mr1, mw1, rw1, rd1, m2r1, asa1, ill1;
  logic pcw2, pcwc2, irw2, iord2, mr2, mw2, rw2, rd2, m2r2, asa2, ill2;
  logic [1:0] asb1, pcs1, asb2, pcs2;
  logic [3:0] aop1, st1, aop2, st2;
  obs_t o1, o2;

  assign o1 = {st1, pcw1, pcwc1, irw1, iord1, mr1, mw1, rw1, rd1, m2r1, asa1, asb1, pcs1, aop1, ill1};
  assign o2 = {st2, pcw2, pcwc2, irw2, iord2, mr2, mw2, rw2, rd2, m2r2, asa2, asb2, pcs2, aop2, ill2};

  mips_multicycle_ctrl #(.ALU_OP_W(4), .MEM_WAIT_EN(1'b1), .ILLEGAL_TRAP(1'b1)) dut1 (
    .clk(clk), .rst(rst1), .op_i(op), .funct_i(funct), .zero_i(zero), .mem_ready_i(mem_ready),
    .pc_write(pcw1), .pc_write_cond(pcwc1), .ir_write(irw1), .iord(iord1), .mem_read(mr1),
    .mem_write(mw1), .reg_write(rw1), .reg_dst(rd1), .mem_to_reg(m2r1), .alu_src_a(asa1),
    .alu_src_b(asb1), .pc_src(pcs1), .alu_op(aop1), .illegal_o(ill1), .state_o(st1));

  mips_multicycle_ctrl #(.ALU_OP_W(4), .MEM_WAIT_EN(1'b0), .ILLEGAL_TRAP(1'b1)) dut2 (
    .clk(clk), .rst(rst2), .op_i(op), .funct_i(funct), .zero_i(zero), .mem_ready_i(mem_ready2),
    .pc_write(pcw2), .pc_write_cond(pcwc2), .ir_write(irw2), .iord(iord2), .mem_read(mr2),
    .mem_write(mw2), .reg_write(rw2), .reg_dst(rd2), .mem_to_reg(m2r2), .alu_src_a(asa2),
    .alu_src_b(asb2), .pc_src(pcs2), .alu_op(aop2), .illegal_o(ill2), .state_o(st2));

  int n_tests = 0;
  int n_fail  = 0;

  // Expected state per DUT for the current cycle, set by the stimulus side.
  logic [3:0] exp_st1, exp_st2;
  bit         act_sel;

  int n_cyc, n_rw, n_ill, n_mw, n_mr_iord, n_add, n_pwc;
  int rw_dst, rw_m2r, ex_alu, wb_alu, br_pcsrc, j_pcsrc;

  function automatic bit fn_known(input logic [5:0] fn);
    return (fn == 6'h20) || (fn == 6'h22) || (fn == 6'h24) || (fn == 6'h25) || (fn == 6'h2A);
  endfunction

  function automatic logic [3:0] fn_alu(input logic [5:0] fn);
    case (fn)
      6'h20:   return 4'h2;
      6'h22:   return 4'h6;
      6'h24:   return 4'h0;
      6'h25:   return 4'h1;
      6'h2A:   return 4'h7;
      default: return 4'h0;
    endcase
  endfunction

  function automatic obs_t model(input logic r, input logic [3:0] st, input logic [5:0] fn,
                                 input logic z, input logic rdy);
    obs_t e = '0;
    if (r) return e;
    e.state = st;
    case (st)
      4'd0:  begin e.mem_read = 1; e.alu_src_b = 2'd1; e.alu_op = 4'h2; e.ir_write = rdy; e.pc_write = rdy; end
      4'd1:  begin e.alu_src_b = 2'd3; e.alu_op = 4'h2; end
      4'd2:  begin e.alu_src_a = 1; e.alu_src_b = 2'd2; e.alu_op = 4'h2; end
      4'd3:  begin e.mem_read = 1; e.iord = 1; end
      4'd4:  begin e.reg_write = 1; e.mem_to_reg = 1; end
      4'd5:  begin e.mem_write = 1; e.iord = 1; end
      4'd6:  begin e.alu_src_a = 1; e.alu_op = fn_alu(fn); end
      4'd7:  begin e.reg_write = 1; e.reg_dst = 1; e.alu_op = fn_alu(fn); end
      4'd8:  begin e.alu_src_a = 1; e.alu_src_b = 2'd2; e.alu_op = 4'h2; end
      4'd9:  e.reg_write = 1;
      4'd10: begin e.alu_src_a = 1; e.alu_op = 4'h6; e.pc_src = 2'd1; e.pc_write_cond = z; end
      4'd11: begin e.pc_write = 1; e.pc_src = 2'd2; end
      4'd12: e.illegal = 1;
      default: e = '0;
    endcase
    return e;
  endfunction

  // alu_op in EXEC is unconstrained for an undecodable funct.
  function automatic obs_t cmp_mask(input logic r, input logic [3:0] st, input logic [5:0] fn);
    obs_t m = '1;
    if (!r && st == 4'd6 && !fn_known(fn)) m.alu_op = 4'h0;
    return m;
  endfunction

  always @(negedge clk) begin
    obs_t e1, e2, m1, m2, ob;
    e1 = model(rst1, exp_st1, funct, zero, mem_ready);
    m1 = cmp_mask(rst1, exp_st1, funct);
    e2 = model(rst2, exp_st2, funct, zero, 1'b1);
    m2 = cmp_mask(rst2, exp_st2, funct);
    n_tests++;
    if (((o1 ^ e1) & m1) != '0) begin
      n_fail++;
      $display("FAIL cycle_dut1 t=%0t exp_state=%0d: got %h expected %h", $time, exp_st1, o1, e1);
    end
    n_tests++;
    if (((o2 ^ e2) & m2) != '0) begin
      n_fail++;
      $display("FAIL cycle_dut2 t=%0t exp_state=%0d: got %h expected %h", $time, exp_st2, o2, e2);
    end
    ob = act_sel ? o2 : o1;
    n_cyc++;
    n_rw      += int'(ob.reg_write);
    n_ill     += int'(ob.illegal);
    n_mw      += int'(ob.mem_write);
    n_mr_iord += int'(ob.mem_read & ob.iord);
    n_pwc     += int'(ob.pc_write_cond);
    if (ob.reg_write) begin rw_dst = int'(ob.reg_dst); rw_m2r = int'(ob.mem_to_reg); end
    if (ob.state == 4'd6)  ex_alu = int'(ob.alu_op);
    if (ob.state == 4'd7)  wb_alu = int'(ob.alu_op);
    if (ob.state == 4'd10) br_pcsrc = int'(ob.pc_src);
    if (ob.state == 4'd11) j_pcsrc = int'(ob.pc_src);
    if ((ob.state == 4'd0 || ob.state == 4'd1 || ob.state == 4'd8) && ob.alu_op == 4'h2) n_add++;
  end

  task automatic chk(input string name, input int act, input int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic clr;
    n_cyc = 0; n_rw = 0; n_ill = 0; n_mw = 0; n_mr_iord = 0; n_add = 0; n_pwc = 0;
    rw_dst = -1; rw_m2r = -1; ex_alu = -1; wb_alu = -1; br_pcsrc = -1; j_pcsrc = -1;
  endtask

  task automatic step1(input logic [3:0] st, input logic rdy);
    exp_st1 = st; mem_ready = rdy;
    @(posedge clk); #1;
  endtask

  // One instruction from FETCH to its last state; fw/mw are memory wait cycles.
  task automatic run(input bit sel, input logic [5:0] o, input logic [5:0] fn, input logic z,
                     input int fw, input int mw);
    logic [3:0] sq[$];
    logic       rq[$];
    op = o; funct = fn; zero = z; act_sel = sel;
    clr();
    for (int i = 0; i < fw; i++) begin sq.push_back(4'd0); rq.push_back(1'b0); end
    sq.push_back(4'd0); rq.push_back(1'b1);
    sq.push_back(4'd1); rq.push_back(1'b1);
    case (o)
      6'h23: begin
        sq.push_back(4'd2); rq.push_back(1'b1);
        for (int i = 0; i < mw; i++) begin sq.push_back(4'd3); rq.push_back(1'b0); end
        sq.push_back(4'd3); rq.push_back(1'b1);
        sq.push_back(4'd4); rq.push_back(1'b1);
      end
      6'h2B: begin
        sq.push_back(4'd2); rq.push_back(1'b1);
        for (int i = 0; i < mw; i++) begin sq.push_back(4'd5); rq.push_back(1'b0); end
        sq.push_back(4'd5); rq.push_back(1'b1);
      end
      6'h00: begin
        sq.push_back(4'd6); rq.push_back(1'b1);
        sq.push_back(fn_known(fn) ? 4'd7 : 4'd12); rq.push_back(1'b1);
      end
      6'h08: begin
        sq.push_back(4'd8); rq.push_back(1'b1);
        sq.push_back(4'd9); rq.push_back(1'b1);
      end
      6'h04:   begin sq.push_back(4'd10); rq.push_back(1'b1); end
      6'h02:   begin sq.push_back(4'd11); rq.push_back(1'b1); end
      default: begin sq.push_back(4'd12); rq.push_back(1'b1); end
    endcase
    foreach (sq[i]) begin
      if (sel) exp_st2 = sq[i];
      else begin exp_st1 = sq[i]; mem_ready = rq[i]; end
      @(posedge clk); #1;
    end
  endtask

  initial begin
    rst1 = 1; rst2 = 1; mem_ready = 1; op = 6'h08; funct = 6'h20; zero = 0;
    exp_st1 = 0; exp_st2 = 0; act_sel = 0;
    clr();
    repeat (2) begin @(posedge clk); #1; end
    chk("reset_outputs_zero", int'(o1), 0);
    chk("reset_state", int'(st1), 0);
    rst1 = 0;

    run(0, 6'h08, 6'h00, 0, 0, 0);
    chk("addi_cycles", n_cyc, 4);
    chk("addi_reg_write_count", n_rw, 1);
    chk("addi_reg_dst", rw_dst, 0);
    chk("addi_alu_add_states", n_add, 3);

    // LW interrupted by reset while waiting in MEMRD.
    op = 6'h23; act_sel = 0;
    step1(4'd0, 1'b1); step1(4'd1, 1'b1); step1(4'd2, 1'b1); step1(4'd3, 1'b0);
    rst1 = 1;
    @(negedge clk); #1;
    chk("midlw_rst_outputs_zero", int'(o1), 0);
    @(posedge clk); #1;
    @(negedge clk); #1;
    chk("midlw_rst_state", int'(st1), 0);
    @(posedge clk); #1;
    rst1 = 0; exp_st1 = 4'd0; mem_ready = 1'b0;
    @(negedge clk); #1;
    chk("post_rst_mem_read", int'(mr1), 1);
    chk("post_rst_iord", int'(iord1), 0);
    chk("post_rst_write_qualifiers", int'({pcw1, irw1, mw1, rw1}), 0);
    @(posedge clk); #1;

    run(0, 6'h23, 6'h00, 0, 0, 2);
    chk("lw_wait_cycles", n_cyc, 7);
    chk("lw_mem_read_iord_cycles", n_mr_iord, 3);
    chk("lw_mem_to_reg", rw_m2r, 1);

    run(0, 6'h00, 6'h2A, 0, 0, 0);
    chk("slt_exec_alu_op", ex_alu, 7);
    chk("slt_aluwb_alu_op", wb_alu, 7);
    chk("slt_reg_dst", rw_dst, 1);
    run(0, 6'h00, 6'h3F, 0, 0, 0);
    chk("badfunct_illegal_pulses", n_ill, 1);
    chk("badfunct_reg_write", n_rw, 0);

    run(0, 6'h04, 6'h00, 1, 0, 0);
    chk("beq_taken_cycles", n_cyc, 3);
    chk("beq_taken_pwc", n_pwc, 1);
    chk("beq_pc_src", br_pcsrc, 1);
    run(0, 6'h04, 6'h00, 0, 0, 0);
    chk("beq_not_taken_pwc", n_pwc, 0);

    run(0, 6'h00, 6'h20, 0, 1, 0);
    run(0, 6'h00, 6'h22, 0, 0, 0);
    chk("sub_exec_alu_op", ex_alu, 6);
    run(0, 6'h00, 6'h24, 0, 0, 0);
    run(0, 6'h00, 6'h25, 0, 0, 0);
    chk("or_aluwb_alu_op", wb_alu, 1);
    run(0, 6'h2B, 6'h00, 0, 0, 1);
    chk("sw_wait_mem_write_cycles", n_mw, 2);
    run(0, 6'h3F, 6'h00, 0, 0, 0);
    chk("badop_cycles", n_cyc, 3);
    chk("badop_illegal_pulses", n_ill, 1);

    // Memory-wait-disabled instance with mem_ready tied low.
    rst1 = 1;
    rst2 = 0;
    run(1, 6'h2B, 6'h00, 0, 0, 0);
    chk("nowait_sw_cycles", n_cyc, 4);
    chk("nowait_sw_mem_write", n_mw, 1);
    run(1, 6'h02, 6'h00, 0, 0, 0);
    chk("nowait_j_cycles", n_cyc, 3);
    chk("nowait_j_pc_src", j_pcsrc, 2);
    run(1, 6'h23, 6'h00, 0, 0, 0);
    chk("nowait_lw_cycles", n_cyc, 5);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/mips_multicycle_ctrl.md
Name: mips_multicycle_ctrl

Overview:
Multicycle MIPS control unit. It generalises the single-cycle opcode decoder into an FSM that sequences fetch, decode, execute, memory and writeback over several clocks. It drives datapath enables and the ALU opcode, and stalls on a memory-ready handshake. It sits between the instruction register (op_i/funct_i) and the shared-memory multicycle datapath.

Parameters:
ALU_OP_W, 4, width of alu_op; must be ≥4 so the shared ALU codes fit.
MEM_WAIT_EN, 1, 1 = memory states wait for mem_ready_i; 0 = mem_ready_i ignored and treated as 1.
ILLEGAL_TRAP, 1, 1 = an unknown opcode/funct pulses illegal_o and returns to FETCH; 0 = it is silently treated as a NOP.

Ports:
clk  in  1  system clock, rising edge.
rst  in  1  synchronous, active-high reset.
op_i  in  6  opcode field of the instruction register.
funct_i  in  6  funct field, R-type only.
zero_i  in  1  ALU zero flag, used for BEQ.
mem_ready_i  in  1  memory has completed the current read or write.
pc_write  out  1  unconditional PC load.
pc_write_cond  out  1  PC load qualified by zero_i; this block already ANDs it with zero_i.
ir_write  out  1  instruction register load.
iord  out  1  memory address select: 0 = PC, 1 = ALUOut.
mem_read  out  1  memory read request.
mem_write  out  1  memory write request.
reg_write  out  1  register file write.
reg_dst  out  1  destination select: 0 = rt, 1 = rd.
mem_to_reg  out  1  writeback select: 0 = ALUOut, 1 = MDR.
alu_src_a  out  1  ALU A select: 0 = PC, 1 = rs.
alu_src_b  out  2  ALU B select: 0 = rt, 1 = const 4, 2 = sign-extended imm, 3 = sign-extended imm << 2.
pc_src  out  2  PC source: 0 = ALU result, 1 = ALUOut, 2 = jump target.
alu_op  out  ALU_OP_W  ALU operation code.
illegal_o  out  1  one-cycle pulse on an undecodable instruction.
state_o  out  4  current state, for debug.

Behaviour:
- Supported instructions: R-type (op 0; funct ADD 0x20, SUB 0x22, AND 0x24, OR 0x25, SLT 0x2A), ADDI 0x08, LW 0x23, SW 0x2B, BEQ 0x04, J 0x02.
- States and encodings:
  - FETCH 0, DECODE 1, MEMADR 2, MEMRD 3, MEMWB 4, MEMWR 5, EXEC 6, ALUWB 7, ADDIEX 8, ADDIWB 9, BRANCH 10, JUMP 11, TRAP 12.
  - Encodings 13–15 are unused and recover to FETCH on the next edge.
- Reset: on a rising edge with rst=1, state becomes FETCH. While rst=1, all outputs are driven 0, including alu_op and illegal_o. Reset mid-instruction aborts it with no pending writes.
- Outputs are a Moore decode of the state, except that the pc_write, ir_write and pc_write_cond qualifiers depend on inputs as stated below. Every output not listed for a state is 0.
- FETCH:
  - Outputs: mem_read=1, iord=0, alu_src_a=0, alu_src_b=1, alu_op=alu_add, pc_src=0.
  - ir_write and pc_write equal effective ready.
  - Stay in FETCH while not ready; go to DECODE when ready.
- DECODE:
  - Outputs: alu_src_a=0, alu_src_b=3, alu_op=alu_add (branch target precompute).
  - Next state: LW/SW→MEMADR, R-type→EXEC, ADDI→ADDIEX, BEQ→BRANCH, J→JUMP.
  - Any other opcode → TRAP if ILLEGAL_TRAP=1, else FETCH.
- MEMADR: alu_src_a=1, alu_src_b=2, alu_op=alu_add. Next state is MEMRD for LW, MEMWR for SW.
- MEMRD: mem_read=1, iord=1. Hold until ready, then go to MEMWB.
- MEMWB: reg_write=1, reg_dst=0, mem_to_reg=1. Next state FETCH.
- MEMWR: mem_write=1, iord=1. Hold until ready, then go to FETCH.
- EXEC:
  - alu_src_a=1, alu_src_b=0, alu_op decoded from funct_i.
  - An unknown funct → TRAP if ILLEGAL_TRAP=1, otherwise FETCH with no writeback. A known funct → ALUWB.
- ALUWB: reg_write=1, reg_dst=1, mem_to_reg=0. alu_op holds the EXEC value. Next state FETCH.
- ADDIEX: alu_src_a=1, alu_src_b=2, alu_op=alu_add. Next state ADDIWB.
- ADDIWB: reg_write=1, reg_dst=0, mem_to_reg=0. Next state FETCH.
- BRANCH: alu_src_a=1, alu_src_b=0, alu_op=alu_sub, pc_src=1, pc_write_cond=zero_i. Next state FETCH.
- JUMP: pc_write=1, pc_src=2. Next state FETCH.
- TRAP: illegal_o=1 for exactly one cycle. Next state FETCH.
- Effective ready = mem_ready_i when MEM_WAIT_EN=1, else 1. mem_read/mem_write stay asserted, with iord stable, for every cycle spent waiting.
- mem_read and mem_write are never both 1. reg_write and pc_write are never both 1.
- op_i/funct_i are sampled combinationally. The IR holds them stable from DECODE until the next FETCH completes.
- Cycle counts with ready=1: LW 5, SW 4, R-type/ADDI 4, BEQ/J 3, TRAP 3.

Decomposition:
- Shared package mips_para.v holds:
  - opcode macros ADDI, LW, SW, BEQ, J, RTYPE;
  - funct macros;
  - ALU codes alu_and 4'h0, alu_or 4'h1, alu_add 4'h2, alu_sub 4'h6, alu_slt 4'h7;
  - state encodings.
- One natural sub-module, alu_decoder: a combinational map funct → alu_op plus a funct_valid flag, used in EXEC.

Test Plan:
- Reset: rst=1 for 2 cycles mid-LW in MEMRD → next cycle state_o=0, all outputs 0 while rst=1; the first post-reset cycle shows mem_read=1, iord=0.
- ADDI: op 0x08, mem_ready_i=1 → states 0,1,8,9,0; reg_write=1 only in state 9 with reg_dst=0; alu_op=4'h2 in states 0, 1 and 8.
- LW with 3-cycle wait: mem_ready_i low for 2 cycles in MEMRD → mem_read=1, iord=1 held for 3 cycles; MEMWB then shows mem_to_reg=1.
- R-type SLT (funct 0x2A) → alu_op=4'h7 in EXEC and ALUWB; reg_dst=1. Then funct 0x3F → illegal_o pulses once and reg_write is never asserted.
- BEQ: zero_i=1 → pc_write_cond=1, pc_src=1 in BRANCH. Repeat with zero_i=0 → pc_write_cond=0.
- MEM_WAIT_EN=0 with mem_ready_i tied 0 → SW completes in 4 cycles with mem_write=1 exactly once; J completes in 3 cycles with pc_src=2.
